// File: rtl/code_mem_pkg.sv
// Shared types and defaults for the code/data memory arbiter.
//   state_t  : arbiter mode (normal arbitration or debug lock)
//   req_id_t : which requester owns the memory port this cycle
package code_mem_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int CNT_W            = 8;   // starvation counter width (limit 1..255)

    typedef enum logic [0:0] {
        ST_RUN,
        ST_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        RQ_NONE,
        RQ_IF,
        RQ_DF,
        RQ_DBG
    } req_id_t;

endpackage

// File: rtl/code_mem_starve_ctr.sv
// Saturating wait counter for the debug requester.
//   clk, reset_n : clock, asynchronous active-low reset
//   waiting      : debug is requesting and was not granted this cycle
//   clear        : debug was granted or is not requesting
//   starved      : counter has reached LIMIT; debug must win next arbitration
module code_mem_starve_ctr
    import code_mem_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic waiting,
    input  logic clear,
    output logic starved
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (clear) begin
            starve_cnt <= '0;
        end else if (waiting && (starve_cnt != LIMIT_C)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starved = (starve_cnt == LIMIT_C);

endmodule

// File: rtl/code_mem_arbiter.sv
// Arbiter for the single-port code/data memory shared by CPU instruction
// fetch (if), CPU data fetch (df) and the debug loader (dbg).
//   clk, reset_n           : clock, asynchronous active-low reset
//   if_req/if_addr         : instruction fetch request; if_gnt, if_rvalid back
//   df_req/df_addr         : data fetch request; df_gnt, df_rvalid back
//   dbg_req/dbg_we/...     : debug read/write; dbg_gnt, dbg_rvalid (reads only)
//   dbg_lock / locked      : debug requests exclusive ownership / lock active
//   rdata                  : shared read-data return (straight from mem_rdata)
//   mem_addr/we/wdata      : memory port driven by the granted requester
//   mem_rdata              : memory read data, one cycle after the address
module code_mem_arbiter
    import code_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              df_req,
    input  logic [ADDR_W-1:0] df_addr,
    output logic              df_gnt,
    output logic              df_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    input  logic              dbg_lock,
    output logic              locked,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t  state_q, state_d;
    req_id_t sel;
    logic    starved;

    code_mem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .waiting (dbg_req && !dbg_gnt),
        .clear   (!dbg_req || dbg_gnt),
        .starved (starved)
    );

    // Mode register and grant selection. The lock request takes effect at the
    // next edge, so a CPU grant in the same cycle as dbg_lock still completes.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sel     = RQ_NONE;
        case (state_q)
            ST_RUN: begin
                if (dbg_lock) state_d = ST_LOCKED;
                if (dbg_req && starved) sel = RQ_DBG;
                else if (df_req)        sel = RQ_DF;
                else if (if_req)        sel = RQ_IF;
                else if (dbg_req)       sel = RQ_DBG;
            end
            ST_LOCKED: begin
                if (!dbg_lock) state_d = ST_RUN;
                if (dbg_req)   sel = RQ_DBG;
            end
            default: ;
        endcase
        // No access may start while reset is held.
        if (!reset_n) sel = RQ_NONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    assign if_gnt  = (sel == RQ_IF);
    assign df_gnt  = (sel == RQ_DF);
    assign dbg_gnt = (sel == RQ_DBG);
    assign locked  = (state_q == ST_LOCKED);

    // Memory-port mux: idle port is driven to all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (sel)
            RQ_IF:  mem_addr = if_addr;
            RQ_DF:  mem_addr = df_addr;
            RQ_DBG: begin
                mem_addr = dbg_addr;
                if (dbg_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = dbg_wdata;
                end
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after the grant; flag its owner then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid  <= 1'b0;
            df_rvalid  <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            if_rvalid  <= if_gnt;
            df_rvalid  <= df_gnt;
            dbg_rvalid <= dbg_gnt && !dbg_we;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_code_mem_arbiter.sv
module tb_code_mem_arbiter;
    import code_mem_pkg::*;

    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, df_req, dbg_req, dbg_we, dbg_lock;
    logic [15:0] if_addr, df_addr, dbg_addr, dbg_wdata;
    logic        if_gnt, if_rvalid, df_gnt, df_rvalid, dbg_gnt, dbg_rvalid, locked;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    code_mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .df_req(df_req), .df_addr(df_addr), .df_gnt(df_gnt), .df_rvalid(df_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_lock(dbg_lock), .locked(locked), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory (environment, 256 words) ----------------
    function automatic logic [15:0] init_word(input int a);
        if (a == 'h13) return 16'h0A00;
        if (a == 'h44) return 16'h3231;
        return {8'(255 - a), 8'(a)};
    endfunction

    logic [15:0] mem [0:255];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:255];
    int          m_wait;          // consecutive cycles dbg has been refused
    bit          m_locked;
    bit          exp_if_rv, exp_df_rv, exp_dbg_rv;
    logic [15:0] exp_rdata;
    bit          g_if, g_df, g_dbg;

    function automatic void model_reset();
        m_wait     = 0;
        m_locked   = 1'b0;
        exp_if_rv  = 1'b0;
        exp_df_rv  = 1'b0;
        exp_dbg_rv = 1'b0;
    endfunction

    // Who should own the port now, from the arbitration rules.
    function automatic req_id_t model_who();
        if (!reset_n)                             return RQ_NONE;
        if (m_locked)                             return dbg_req ? RQ_DBG : RQ_NONE;
        if (dbg_req && m_wait >= STARVE_LIMIT)    return RQ_DBG;
        if (df_req)                               return RQ_DF;
        if (if_req)                               return RQ_IF;
        if (dbg_req)                              return RQ_DBG;
        return RQ_NONE;
    endfunction

    function automatic void model_step(input req_id_t w);
        if (!reset_n) begin
            model_reset();
            return;
        end
        exp_if_rv  = (w == RQ_IF);
        exp_df_rv  = (w == RQ_DF);
        exp_dbg_rv = (w == RQ_DBG) && !dbg_we;
        case (w)
            RQ_IF:  exp_rdata = ref_mem[if_addr[7:0]];
            RQ_DF:  exp_rdata = ref_mem[df_addr[7:0]];
            RQ_DBG: begin
                if (dbg_we) ref_mem[dbg_addr[7:0]] = dbg_wdata;
                else        exp_rdata = ref_mem[dbg_addr[7:0]];
            end
            default: ;
        endcase
        if (dbg_req && w != RQ_DBG) m_wait++;
        else                        m_wait = 0;
        m_locked = dbg_lock;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_registered();
        check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
        check("df_rvalid", 32'(df_rvalid), 32'(exp_df_rv));
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_dbg_rv));
        check("locked", 32'(locked), 32'(m_locked));
        if (exp_if_rv || exp_df_rv || exp_dbg_rv)
            check("rdata", 32'(rdata), 32'(exp_rdata));
    endtask

    // One clock: entered at negedge with inputs set, returns at next negedge.
    task automatic cycle();
        req_id_t     w;
        logic [15:0] ea, ed;
        logic        ewe;
        #1;
        w     = model_who();
        g_if  = if_gnt;
        g_df  = df_gnt;
        g_dbg = dbg_gnt;
        check("if_gnt", 32'(if_gnt), 32'(w == RQ_IF));
        check("df_gnt", 32'(df_gnt), 32'(w == RQ_DF));
        check("dbg_gnt", 32'(dbg_gnt), 32'(w == RQ_DBG));
        ea = '0; ed = '0; ewe = 1'b0;
        case (w)
            RQ_IF:  ea = if_addr;
            RQ_DF:  ea = df_addr;
            RQ_DBG: begin
                ea = dbg_addr;
                if (dbg_we) begin
                    ewe = 1'b1;
                    ed  = dbg_wdata;
                end
            end
            default: ;
        endcase
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_wdata", 32'(mem_wdata), 32'(ed));
        @(posedge clk);
        model_step(w);
        #1;
        check_registered();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        exp_rdata = '0;
        reset_n = 1'b0;
        if_req = 1'b1; df_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b0;
        if_addr = 16'h0; df_addr = 16'h0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        @(negedge clk);

        // Reset: no grants with requests present, outputs at reset values.
        cycle();
        cycle();
        if_req = 1'b0; df_req = 1'b0; dbg_req = 1'b0;
        reset_n = 1'b1;
        cycle();

        // Single instruction fetch.
        if_req = 1'b1; if_addr = 16'h0013;
        cycle();
        check("plan_if_gnt", 32'(g_if), 32'd1);
        check("plan_if_rdata", 32'(rdata), 32'h0A00);
        if_req = 1'b0;
        cycle();

        // if and df collide: df first, if on the next cycle.
        if_req = 1'b1; if_addr = 16'h0020; df_req = 1'b1; df_addr = 16'h0044;
        cycle();
        check("plan_df_first", 32'(g_df), 32'd1);
        check("plan_df_rdata", 32'(rdata), 32'h3231);
        df_req = 1'b0;
        cycle();
        check("plan_if_after_df", 32'(g_if), 32'd1);

        // Starvation: if held permanently, dbg read waits STARVE_LIMIT cycles.
        if_addr = 16'h0030; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0001;
        got = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (g_dbg) begin
                got = n;
                break;
            end
        end
        check("plan_starve_cycle", 32'(got), 32'(STARVE_LIMIT + 1));
        check("plan_starve_no_if", 32'(g_if), 32'd0);
        dbg_req = 1'b0;

        // Lock with if held: write then read back through the locked port.
        dbg_lock = 1'b1;
        cycle();
        check("plan_locked_rise", 32'(locked), 32'd1);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0001; dbg_wdata = 16'h0009;
        cycle();
        check("plan_locked_no_if", 32'(g_if), 32'd0);
        dbg_we = 1'b0;
        cycle();
        check("plan_dbg_readback", 32'(rdata), 32'h0009);
        check("plan_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        dbg_req = 1'b0;
        cycle();
        dbg_lock = 1'b0;
        cycle();
        check("plan_unlock_no_if", 32'(g_if), 32'd0);
        cycle();
        check("plan_if_resumes", 32'(g_if), 32'd1);

        // Lock raised in the same cycle as a df grant.
        if_req = 1'b0; df_req = 1'b1; df_addr = 16'h0044; dbg_lock = 1'b1;
        cycle();
        check("plan_lock_df_gnt", 32'(g_df), 32'd1);
        check("plan_lock_df_rvalid", 32'(df_rvalid), 32'd1);
        check("plan_lock_same_cycle", 32'(locked), 32'd1);
        df_req = 1'b0; dbg_lock = 1'b0;
        cycle();
        cycle();

        // Reset mid-operation with a partial dbg wait and an if grant in flight.
        if_req = 1'b1; if_addr = 16'h0013; dbg_req = 1'b1; dbg_addr = 16'h0002;
        for (int n = 0; n < 4; n++) cycle();
        dbg_lock = 1'b1;
        cycle();
        reset_n = 1'b0;
        dbg_lock = 1'b0;
        #1;
        model_reset();
        check("plan_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("plan_rst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
        got = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (g_dbg) begin
                got = n;
                break;
            end
        end
        check("plan_rst_starve_cleared", 32'(got), 32'(STARVE_LIMIT + 1));
        if_req = 1'b0; dbg_req = 1'b0;
        cycle();

        // Randomized traffic; each requester holds its request until granted.
        g_if = 1'b0; g_df = 1'b0; g_dbg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!if_req || g_if) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = 16'($urandom_range(0, 255));
            end
            if (!df_req || g_df) begin
                df_req  = ($urandom_range(0, 2) == 0);
                df_addr = 16'($urandom_range(0, 255));
            end
            if (!dbg_req || g_dbg) begin
                dbg_req   = ($urandom_range(0, 2) == 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 16'($urandom_range(0, 255));
                dbg_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
